// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and default sizes for the sweep controller
package sweep_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DWELL_DEF = 2;
  localparam int SCNT_W = 4;
  localparam int DWELL_W = 4;
  typedef enum logic [2:0] {IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE} state_t;
endpackage

// File: rtl/sweep_if.sv
// sweep_if: run request/limits in, counter and status out
interface sweep_if import sweep_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
  logic start, abort;
  logic [WIDTH-1:0] lo_lim, hi_lim, count;
  logic [3:0] cycles;
  logic up_down, busy, done, err;
  logic [SCNT_W-1:0] sweep_cnt;
  modport master (output start, abort, lo_lim, hi_lim, cycles,
                  input count, up_down, busy, done, err, sweep_cnt);
  modport slave (input start, abort, lo_lim, hi_lim, cycles,
                 output count, up_down, busy, done, err, sweep_cnt);
endinterface

// File: rtl/sweep_counter.sv
// sweep_counter: loadable up/down counter; holds unless loaded or enabled
module sweep_counter #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_d, count_q;
  // load wins over stepping; FSM only enables away from the limits, so no wrap
  always_comb count_d = load ? load_val : en ? (up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1)) : count_q;
  // counter register, cleared asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: up/down sweep FSM between latched limits; SWEEP_CTRL_DWELL_EN adds turnaround dwell states
module sweep_ctrl import sweep_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input logic    clk,
  input logic    reset,
  sweep_if.slave bus
);
  state_t state_d, state_q;
  logic [WIDTH-1:0] lo_d, lo_q, hi_d, hi_q, count;
  logic [3:0] cyc_d, cyc_q;
  logic [SCNT_W-1:0] scnt_d, scnt_q;
  logic ud_d, ud_q, err_d, err_q, load, en;
`ifdef SWEEP_CTRL_DWELL_EN
  logic [DWELL_W-1:0] dw_d, dw_q;
`endif
  if (DWELL < 1 || DWELL > 15) begin : g_dwell_chk
    $error("DWELL must be 1..15");
  end
  sweep_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .en(en), .up_down(ud_q),
    .load_val(bus.lo_lim), .count(count)
  );
  // next state, latched run parameters and counter controls; abort overrides everything
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    hi_d = hi_q;
    cyc_d = cyc_q;
    scnt_d = scnt_q;
    ud_d = ud_q;
    err_d = 1'b0;
    load = 1'b0;
    en = 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
    dw_d = '0;
`endif
    if (bus.abort && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (bus.start) begin
            if (bus.lo_lim < bus.hi_lim) begin
              lo_d = bus.lo_lim;
              hi_d = bus.hi_lim;
              cyc_d = bus.cycles;
              scnt_d = '0;
              ud_d = 1'b1;
              load = 1'b1;
              state_d = UP;
            end else err_d = 1'b1;
          end
        UP:
          if (count == hi_q) begin
`ifdef SWEEP_CTRL_DWELL_EN
            state_d = DWELL_HI;
`else
            state_d = DOWN;
            ud_d = 1'b0;
`endif
          end else en = 1'b1;
`ifdef SWEEP_CTRL_DWELL_EN
        DWELL_HI:
          if (dw_q == DWELL_W'(DWELL - 1)) begin
            state_d = DOWN;
            ud_d = 1'b0;
          end else dw_d = dw_q + DWELL_W'(1);
        DWELL_LO:
          if (dw_q == DWELL_W'(DWELL - 1)) begin
            state_d = UP;
            ud_d = 1'b1;
          end else dw_d = dw_q + DWELL_W'(1);
`endif
        DOWN:
          if (count == lo_q) begin
            scnt_d = scnt_q + SCNT_W'(1);
            if (cyc_q != 4'd0 && scnt_d == cyc_q) state_d = DONE;
            else begin
`ifdef SWEEP_CTRL_DWELL_EN
              state_d = DWELL_LO;
`else
              state_d = UP;
              ud_d = 1'b1;
`endif
            end
          end else en = 1'b1;
        default: state_d = IDLE;
      endcase
  end
  // control registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      cyc_q <= '0;
      scnt_q <= '0;
      ud_q <= 1'b1;
      err_q <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
      dw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      cyc_q <= cyc_d;
      scnt_q <= scnt_d;
      ud_q <= ud_d;
      err_q <= err_d;
`ifdef SWEEP_CTRL_DWELL_EN
      dw_q <= dw_d;
`endif
    end
  assign bus.count = count;
  assign bus.up_down = ud_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.err = err_q;
  assign bus.sweep_cnt = scnt_q;
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the counter datapath and limits.
REQ-002 Parameter DWELL, default 2: dwell cycles at each turnaround point (1..15).
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 start  input  1  request a sweep run; sampled only in IDLE.
REQ-006 abort  input  1  terminate the run; effective in any non-IDLE state.
REQ-007 lo_lim  input  WIDTH  lower sweep limit; latched on accepted start.
REQ-008 hi_lim  input  WIDTH  upper sweep limit; latched on accepted start.
REQ-009 cycles  input  4  number of full up/down sweeps; 0 = continuous; latched on start.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 up_down  output  1  current direction; 1 = up, 0 = down.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 err  output  1  one-cycle pulse when start is rejected for illegal limits.
REQ-015 sweep_cnt  output  4  completed sweeps in the current run.

Function
REQ-016 States SHALL be IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE; all transitions occur on rising clk.
REQ-017 In IDLE with start=1 and lo_lim<hi_lim: latch limits and cycles, set count<=lo_lim, sweep_cnt<=0, up_down<=1, next state UP.
REQ-018 In IDLE with start=1 and lo_lim>=hi_lim: stay IDLE, pulse err for one cycle, count unchanged.
REQ-019 UP: if count==hi, go to DWELL_HI with count held; otherwise count<=count+1.
REQ-020 DWELL_HI: hold count for exactly DWELL cycles, then set up_down<=0 and go to DOWN.
REQ-021 DOWN: if count==lo, sweep_cnt<=sweep_cnt+1 and evaluate completion; otherwise count<=count-1.
REQ-022 Completion: if cycles!=0 and sweep_cnt+1==cycles, go to DONE; otherwise go to DWELL_LO.
REQ-023 DWELL_LO: hold count for DWELL cycles, then set up_down<=1 and go to UP.
REQ-024 DONE: assert done for one cycle, go to IDLE; count stays at lo.
REQ-025 Continuous mode (cycles=0): sweep_cnt SHALL wrap 15->0 and the run SHALL continue until abort.
REQ-026 abort=1 in any non-IDLE state: next state IDLE, count and sweep_cnt hold, done not asserted; abort has priority over every other transition.
REQ-027 start while busy SHALL be ignored; limit inputs SHALL not affect an active run.
REQ-028 count SHALL never leave [lo, hi]; no arithmetic wrap SHALL occur.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, count=0, up_down=1, busy=0, done=0, err=0, sweep_cnt=0, and clear latched limits.
REQ-030 Reset asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-031 Macro SWEEP_CTRL_DWELL_EN defined: DWELL_HI/DWELL_LO states exist and behave per REQ-020/REQ-023.
REQ-032 Macro SWEEP_CTRL_DWELL_EN undefined: dwell states are removed; UP at hi goes directly to DOWN, and DOWN at lo (not complete) goes directly to UP, with the direction flip in the same edge.

Structure
REQ-033 Shared package sweep_pkg SHALL hold the state enum typedef, the default WIDTH/DWELL constants, and the sweep_cnt width.
REQ-034 The counter datapath SHALL be a sub-module sweep_counter (load, enable, up_down, count) instantiated once; the FSM and dwell timer remain in sweep_ctrl.

Verification
REQ-035 Apply reset=0 mid-count at count=7 -> count=0, busy=0, state IDLE immediately, without waiting for a clock edge.
REQ-036 With DWELL_EN set, lo=2, hi=5, cycles=1, and start pulsed -> count sequence 2,3,4,5, then 5 held for 2 dwell cycles, then 4,3,2; sweep_cnt=1; a single done pulse; busy falls.
REQ-037 lo=9, hi=9 with start pulsed -> err pulse for 1 cycle, busy stays 0, count unchanged.
REQ-038 lo=0, hi=15, cycles=0 -> at least 2 sweeps pass with no done pulse; count never wraps past 15 or below 0; abort -> IDLE next cycle with count held.
REQ-039 With DWELL_EN undefined, lo=1, hi=3, cycles=2 -> sequence 1,2,3,3,2,1,1,2,3,3,2,1; done after the second sweep; sweep_cnt=2.
REQ-040 start pulsed while busy with new limits -> ignored; the active run completes with the original limits.
